// File: rtl/instr_load_mem.sv
// Instruction memory fed by the serial program-load stream.
// It serves the fetch port and returns NOP for words that were never loaded.
module instr_load_mem #(
  parameter int          DEPTH    = 64,
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic              LoadInstructions,
  input  logic [31:0]       Instruction,
  input  logic [31:0]       PC,
  output logic [31:0]       Instr_out,
  output logic [ADDR_W:0]   load_count,
  output logic              load_done,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_e;

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  state_e            state_q;
  logic [ADDR_W:0]   ptr_q;
  logic [DEPTH-1:0]  valid_q;
  logic              ovf_q;
  logic              done_q;
  logic [31:0]       mem_q [DEPTH];

  logic              start;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_idx;
  logic [ADDR_W-1:0] rd_idx;
  logic              pc_hi;
  logic              unused_pc;

  // A load beat outside LOAD always opens a fresh session at word 0
  assign start  = LoadInstructions && (state_q != LOAD);
  assign wr_en  = start ||
                  (LoadInstructions && (state_q == LOAD) && (ptr_q != FULL));
  assign wr_idx = start ? '0 : ptr_q[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= Instruction;
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      valid_q <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, READY: begin
          if (LoadInstructions) begin
            valid_q <= {{(DEPTH-1){1'b0}}, 1'b1};
            ptr_q   <= (ADDR_W+1)'(1);
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (LoadInstructions) begin
            if (ptr_q != FULL) begin
              valid_q[ptr_q[ADDR_W-1:0]] <= 1'b1;
              ptr_q <= ptr_q + 1'b1;
            end else begin
              ovf_q <= 1'b1;
            end
          end else begin
            done_q  <= 1'b1;
            state_q <= READY;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_idx    = PC[ADDR_W+1:2];
  assign pc_hi     = |PC[31:ADDR_W+2];
  assign unused_pc = ^PC[1:0];

  // A partial program is never exposed while loading
  always_comb begin
    Instr_out = NOP_WORD;
    if ((state_q != LOAD) && !pc_hi && valid_q[rd_idx])
      Instr_out = mem_q[rd_idx];
  end

  assign load_count = ptr_q;
  assign load_done  = done_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_instr_load_mem.sv
// Randomized bench for instr_load_mem against a program-queue model.
// Directed literal checks pin the model to the documented scenarios.
module tb_instr_load_mem;

  logic        clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        LoadInstructions = 1'b0;
  logic [31:0] Instruction = '0;
  logic [31:0] PC = '0;
  logic [31:0] Instr_out;
  logic [6:0]  load_count;
  logic        load_done;
  logic        overflow;

  instr_load_mem dut (
    .clk(clk), .Reset_n(Reset_n),
    .LoadInstructions(LoadInstructions), .Instruction(Instruction),
    .PC(PC), .Instr_out(Instr_out), .load_count(load_count),
    .load_done(load_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit chk_en = 0;

  // Model: the words of the current session, sticky drop flag, phase
  logic [31:0] prog[$];
  bit          m_ov = 0;
  int          m_ph = 0; // 0 idle, 1 loading, 2 ready

  always @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      prog.delete();
      m_ov = 0;
      m_ph = 0;
    end else if (LoadInstructions) begin
      if (m_ph != 1) begin
        prog.delete();
        prog.push_back(Instruction);
        m_ov = 0;
        m_ph = 1;
      end else if (prog.size() < 64) begin
        prog.push_back(Instruction);
      end else begin
        m_ov = 1;
      end
    end else if (m_ph == 1) begin
      m_ph = 2;
    end
  end

  function automatic logic [31:0] exp_fetch(input logic [31:0] pc);
    int idx;
    if (m_ph == 1) return 32'h0;
    if (pc >= 32'h100) return 32'h0;
    idx = int'(pc >> 2);
    if (idx < prog.size()) return prog[idx];
    return 32'h0;
  endfunction

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total_cnt++;
    if (a !== e)
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    else
      pass_cnt++;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("instr_out", Instr_out, exp_fetch(PC));
      chk("load_count", 32'(load_count), 32'(prog.size()));
      chk("load_done", 32'(load_done), 32'(m_ph == 2));
      chk("overflow", 32'(overflow), 32'(m_ov));
    end
  end

  task automatic cyc(input logic l, input logic [31:0] w);
    @(negedge clk);
    #1;
    LoadInstructions = l;
    Instruction = w;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] e,
                       input string n);
    @(negedge clk);
    #1;
    PC = pc;
    #1;
    chk(n, Instr_out, e);
  endtask

  task automatic outs(input logic [31:0] cnt, input logic dn,
                      input logic ov, input string n);
    chk({n, "_count"}, 32'(load_count), cnt);
    chk({n, "_done"}, 32'(load_done), 32'(dn));
    chk({n, "_ovf"}, 32'(overflow), 32'(ov));
  endtask

  int burst;
  logic [31:0] w;

  initial begin
    #3 Reset_n = 1'b0;
    #1;
    outs(0, 0, 0, "rst");
    chk("rst_fetch", Instr_out, 32'h0);
    #4 Reset_n = 1'b1;
    chk_en = 1;

    // 11-word program
    for (int k = 0; k < 11; k++) begin
      w = (k == 0) ? 32'h200101A7 :
          (k == 10) ? 32'h00E24020 : $urandom;
      cyc(1, w);
      if (k == 4) begin
        @(posedge clk);
        #2 PC = 32'h0;
        #1 chk("loading_nop", Instr_out, 32'h0);
      end
    end
    cyc(0, 0);
    @(negedge clk);
    #1;
    outs(11, 1, 0, "prog11");
    fetch(32'h00, 32'h200101A7, "pc00");
    fetch(32'h28, 32'h00E24020, "pc28");
    fetch(32'h2C, 32'h0, "pc2c");
    fetch(32'h2A, 32'h00E24020, "pc2a");
    fetch(32'h100, 32'h0, "pc100");

    // overflow session
    for (int k = 0; k < 66; k++) cyc(1, 32'(k + 1));
    cyc(0, 0);
    @(negedge clk);
    #1;
    outs(64, 1, 1, "ovf");
    fetch(32'hFC, 32'h40, "ovf_pcfc");
    fetch(32'h00, 32'h1, "ovf_pc0");

    // reload from READY
    cyc(1, 32'hA);
    cyc(1, 32'hB);
    cyc(1, 32'hC);
    cyc(0, 0);
    @(negedge clk);
    #1;
    outs(3, 1, 0, "reload");
    fetch(32'h08, 32'hC, "reload_pc8");
    fetch(32'h0C, 32'h0, "reload_pcc");

    // reset in the middle of a session
    for (int k = 0; k < 5; k++) cyc(1, 32'h1000 + 32'(k));
    @(negedge clk);
    LoadInstructions = 1'b0;
    #2 Reset_n = 1'b0;
    PC = 32'h0;
    #1;
    outs(0, 0, 0, "midrst");
    chk("midrst_fetch", Instr_out, 32'h0);
    #1 Reset_n = 1'b1;
    cyc(1, 32'hDEAD0001);
    cyc(1, 32'hDEAD0002);
    cyc(0, 0);
    @(negedge clk);
    #1;
    outs(2, 1, 0, "after_rst");
    fetch(32'h0, 32'hDEAD0001, "after_rst_pc0");

    // randomized traffic
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      if (burst == 0 && $urandom_range(0, 5) == 0)
        burst = ($urandom_range(0, 7) == 0) ? $urandom_range(60, 75)
                                            : $urandom_range(1, 20);
      cyc(burst > 0, $urandom);
      if (burst > 0) burst--;
      PC = ($urandom_range(0, 7) == 0) ? $urandom
                                       : 32'($urandom_range(0, 255));
      if ($urandom_range(0, 399) == 0) begin
        #1 Reset_n = 1'b0;
        #1 Reset_n = 1'b1;
        burst = 0;
      end
    end

    cyc(0, 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_en = 0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
